// File: rtl/gp_prefix_add_pipe_21.sv
// Three-stage valid/ready 21-bit prefix adder: S1 forms bit p/g, S2 latches the
// group-PG network output, S3 applies carry-in and registers sum/cout/ovf.

module GP_Gen_1_21 (
    input  logic [21:1] i_p,
    input  logic [21:1] i_g,
    output logic [21:1] o_P,
    output logic [21:1] o_G
);
    // Kogge-Stone: after level l, bit i covers the span [i : max(1, i-2^(l+1)+1)].
    logic [21:1] w_gg, w_pp, w_ng, w_np;

    always_comb begin
        w_gg = i_g;
        w_pp = i_p;
        w_ng = '0;
        w_np = '0;
        for (int l = 0; l < 5; l++) begin
            w_ng = w_gg;
            w_np = w_pp;
            for (int i = 1; i <= 21; i++) begin
                if (i > (1 << l)) begin
                    w_ng[i] = w_gg[i] | (w_pp[i] & w_gg[i - (1 << l)]);
                    w_np[i] = w_pp[i] & w_pp[i - (1 << l)];
                end
            end
            w_gg = w_ng;
            w_pp = w_np;
        end
        o_G = w_gg;
        o_P = w_pp;
    end
endmodule

module gp_prefix_add_pipe_21 #(
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:1]   in_a,
    input  logic [WIDTH:1]   in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:1]   out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             busy
);
    logic             r_v1, r_v2, r_v3;
    logic             w_rdy1, w_rdy2, w_rdy3;

    logic [WIDTH:1]   r1_p, r1_g;
    logic             r1_cin, r1_as, r1_bs;

    logic [WIDTH:1]   w_P, w_G;
    logic [WIDTH:1]   r2_P, r2_G, r2_p;
    logic             r2_cin, r2_as, r2_bs;

    logic [WIDTH:0]   w_c;
    logic [WIDTH:1]   w_sum;
    logic [WIDTH:1]   r3_sum;
    logic             r3_cout, r3_ovf;

    assign w_rdy3   = !r_v3 | out_ready;
    assign w_rdy2   = !r_v2 | w_rdy3;
    assign w_rdy1   = !r_v1 | w_rdy2;
    // Flush empties every stage, so the block can always take the (dropped) beat.
    assign in_ready = w_rdy1 | flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (flush) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else begin
            if (w_rdy1) r_v1 <= in_valid;
            if (w_rdy2) r_v2 <= r_v1;
            if (w_rdy3) r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk) begin
        if (w_rdy1) begin
            r1_p   <= in_a ^ in_b;
            r1_g   <= in_a & in_b;
            r1_cin <= in_cin;
            r1_as  <= in_a[WIDTH];
            r1_bs  <= in_b[WIDTH];
        end
    end

    GP_Gen_1_21 u_net (
        .i_p (r1_p),
        .i_g (r1_g),
        .o_P (w_P),
        .o_G (w_G)
    );

    always_ff @(posedge clk) begin
        if (w_rdy2) begin
            r2_P   <= w_P;
            r2_G   <= w_G;
            r2_p   <= r1_p;
            r2_cin <= r1_cin;
            r2_as  <= r1_as;
            r2_bs  <= r1_bs;
        end
    end

    always_comb begin
        w_c    = '0;
        w_c[0] = r2_cin;
        for (int i = 1; i <= WIDTH; i++)
            w_c[i] = r2_G[i] | (r2_P[i] & r2_cin);
        w_sum = r2_p ^ w_c[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (w_rdy3) begin
            r3_sum  <= w_sum;
            r3_cout <= w_c[WIDTH];
            r3_ovf  <= (r2_as == r2_bs) && (w_sum[WIDTH] != r2_as);
        end
    end

    assign out_valid = r_v3;
    assign out_sum   = r3_sum;
    assign out_cout  = r3_cout;
    assign out_ovf   = r3_ovf;
    assign busy      = r_v1 | r_v2 | r_v3;
endmodule

// File: tb/tb_gp_prefix_add_pipe_21.sv
// Directed bench for gp_prefix_add_pipe_21: vector table plus streaming,
// backpressure, flush and asynchronous-reset sequences.

module tb_gp_prefix_add_pipe_21;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [21:1] in_a = '0;
    logic [21:1] in_b = '0;
    logic        in_cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [21:1] out_sum;
    logic        out_cout;
    logic        out_ovf;
    logic        busy;

    gp_prefix_add_pipe_21 dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [21:1] q_sum[$];
    int          q_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every completed output handshake.
    always @(negedge clk)
        if (rst_n && out_valid && out_ready) begin
            q_sum.push_back(out_sum);
            q_cyc.push_back(cyc);
        end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [21:1] a;
        logic [21:1] b;
        logic        cin;
        logic [21:1] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t tv[9];

    task automatic one_beat(input vec_t v, input string tag);
        in_a = v.a; in_b = v.b; in_cin = v.cin; in_valid = 1'b1;
        chk({tag, ".in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk({tag, ".lat1"}, out_valid, 0);
        tick();
        chk({tag, ".lat2"}, out_valid, 0);
        tick();
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".sum"}, out_sum, v.s);
        chk({tag, ".cout"}, out_cout, v.co);
        chk({tag, ".ovf"}, out_ovf, v.ov);
        tick();
        chk({tag, ".drained"}, out_valid, 0);
    endtask

    initial begin
        tv[0] = '{21'h1FFFFF, 21'h000001, 1'b0, 21'h000000, 1'b1, 1'b0};
        tv[1] = '{21'h0FFFFF, 21'h000001, 1'b0, 21'h100000, 1'b0, 1'b1};
        tv[2] = '{21'h100000, 21'h100000, 1'b0, 21'h000000, 1'b1, 1'b1};
        tv[3] = '{21'h000000, 21'h000000, 1'b1, 21'h000001, 1'b0, 1'b0};
        tv[4] = '{21'h1FFFFF, 21'h1FFFFF, 1'b1, 21'h1FFFFF, 1'b1, 1'b0};
        tv[5] = '{21'h0AAAAA, 21'h155555, 1'b0, 21'h1FFFFF, 1'b0, 1'b0};
        tv[6] = '{21'h0FFFFF, 21'h0FFFFF, 1'b1, 21'h1FFFFF, 1'b0, 1'b1};
        tv[7] = '{21'h012345, 21'h06789A, 1'b0, 21'h079BDF, 1'b0, 1'b0};
        tv[8] = '{21'h1FFFFF, 21'h000000, 1'b1, 21'h000000, 1'b1, 1'b0};

        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rst.out_valid", out_valid, 0);
        chk("rst.busy", busy, 0);
        chk("rst.in_ready", in_ready, 1);

        for (int i = 0; i < 9; i++) one_beat(tv[i], $sformatf("vec%0d", i));

        // Streaming: 8 back-to-back beats, out_ready held high.
        q_sum.delete(); q_cyc.delete();
        for (int k = 0; k < 8; k++) begin
            in_a = 21'(k); in_b = 21'(3 * k); in_cin = k[0]; in_valid = 1'b1;
            chk($sformatf("stream.in_ready%0d", k), in_ready, 1);
            tick();
        end
        in_valid = 1'b0;
        repeat (5) tick();
        chk("stream.count", q_sum.size(), 8);
        for (int k = 0; k < 8 && k < q_sum.size(); k++) begin
            chk($sformatf("stream.sum%0d", k), q_sum[k], 4 * k + (k & 1));
            chk($sformatf("stream.cyc%0d", k), q_cyc[k] - q_cyc[0], k);
        end

        // Backpressure: three beats stalled for five cycles, then drain.
        q_sum.delete(); q_cyc.delete();
        out_ready = 1'b0;
        for (int j = 1; j <= 3; j++) begin
            in_a = 21'(100 * j); in_b = 21'(7); in_cin = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        for (int t = 0; t < 5; t++) begin
            chk($sformatf("bp.in_ready%0d", t), in_ready, 0);
            chk($sformatf("bp.valid%0d", t), out_valid, 1);
            chk($sformatf("bp.sum%0d", t), out_sum, 107);
            tick();
        end
        out_ready = 1'b1;
        repeat (4) tick();
        chk("bp.count", q_sum.size(), 3);
        for (int j = 0; j < 3 && j < q_sum.size(); j++)
            chk($sformatf("bp.order%0d", j), q_sum[j], 100 * (j + 1) + 7);

        // Flush with two beats in flight plus one offered in the flush cycle.
        q_sum.delete(); q_cyc.delete();
        for (int j = 0; j < 2; j++) begin
            in_a = 21'(50 + j); in_b = 21'(1); in_cin = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_a = 21'h55; in_b = 21'h1; flush = 1'b1;
        chk("flush.in_ready", in_ready, 1);
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush.out_valid", out_valid, 0);
        chk("flush.busy", busy, 0);
        repeat (4) tick();
        chk("flush.no_output", q_sum.size(), 0);
        one_beat('{21'h000123, 21'h000456, 1'b1, 21'h00057A, 1'b0, 1'b0}, "postflush");

        // Asynchronous reset between edges with three beats in flight.
        q_sum.delete(); q_cyc.delete();
        for (int j = 0; j < 3; j++) begin
            in_a = 21'(9 + j); in_b = 21'(9); in_cin = 1'b0; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        chk("arst.pre_valid", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 0);
        chk("arst.busy", busy, 0);
        q_sum.delete(); q_cyc.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (5) tick();
        chk("arst.no_stale", q_sum.size(), 0);
        chk("arst.in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
